addsub_stream_ctrl: RTL
=======================

Name: addsub_stream_ctrl

Overview:
- Initiator and collector for the single-cycle BF16/INT8 add/sub unit.
- Buffers host operand pairs in an operand FIFO and issues one pair per cycle to the adder, with credit-based flow control.
- Applies the subtract transform to operand b before issue.
- Aligns the adder's combinational overflow flag with the adder's registered result, and queues results in a result FIFO with ready/valid output.
- Runs in batches of batch_len operations, under start/busy/done control.

Parameters:
OP_DEPTH, 8, operand FIFO depth (power of 2, ≥2)
RES_DEPTH, 8, result FIFO depth (power of 2, ≥2)
LAT, 1, adder latency in cycles from add_vld to add_res_vld
LW, 8, width of batch_len

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_op_a  in  16  operand a (BF16, or INT8 in [7:0])
s_op_b  in  16  operand b
s_op_int8  in  1  1 = INT8 operation
s_op_sub  in  1  1 = compute a−b
s_op_valid  in  1  operand pair valid
s_op_ready  out  1  operand FIFO not full
start  in  1  begin batch (sampled in IDLE only)
batch_len  in  LW  number of operations in the batch, latched on start
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at batch completion
add_a  out  16  adder operand a
add_b  out  16  adder operand b (after subtract transform)
add_int8  out  1  adder mode
add_vld  out  1  issue strobe
add_res  in  16  adder registered result
add_res_vld  in  1  adder result valid
add_ovf  in  1  adder overflow; combinational on add_a/add_b in the issue cycle
m_res  out  16  result
m_res_ovf  out  1  overflow flag aligned with m_res
m_res_valid  out  1  result FIFO not empty
m_res_ready  in  1  consumer accepts result
ovf_count  out  8  overflows in the current batch; saturates at 255

Behaviour:
- Reset values:
  - Both FIFOs empty.
  - FSM in IDLE.
  - busy=0, done=0, add_vld=0, add_a=add_b=0, add_int8=0.
  - m_res_valid=0, ovf_count=0.
  - s_op_ready=1 from the first cycle after reset.
- Operand FIFO:
  - Push when s_op_valid && s_op_ready.
  - Pushing is independent of FSM state; operands may be preloaded in IDLE.
  - Each entry stores {a, b, int8, sub}.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches batch_len and clears ovf_count and the issue counter.
  - If batch_len=0, go to IDLE and pulse done next cycle; otherwise go to RUN.
  - start while busy is ignored.
- RUN, issue condition:
  - issue = operand FIFO non-empty && issued < batch_len && (res_count + inflight) < RES_DEPTH.
- RUN, on issue:
  - Pop the FIFO head; add_vld=1.
  - add_a = head a.
  - add_int8 = head int8.
  - add_b = head b, except when sub=1:
    - BF16: bit 15 inverted.
    - INT8: {8'h00, (~b[7:0])+1}, 8-bit wrap (−(−128) gives 0x80).
- RUN, when not issuing: add_vld=0 and add_a/add_b/add_int8 are driven 0.
- The add_* outputs are combinational from the FIFO head and the issue condition.
- RUN exit: after the issue that makes issued == batch_len, go to DRAIN.
- DRAIN: when inflight==0 and no result is arriving this cycle, pulse done for one cycle and go to IDLE.
- inflight counter: +1 on issue, −1 on add_res_vld; simultaneous increment and decrement leaves it unchanged; never exceeds LAT.
- Overflow alignment:
  - add_ovf is sampled in the issue cycle (gated by add_vld) into a LAT-stage shift register.
  - The delayed bit is written alongside add_res when add_res_vld=1.
  - ovf_count increments on that write if the bit is 1, saturating at 255.
- Result FIFO:
  - Write on add_res_vld; read on m_res_valid && m_res_ready.
  - Simultaneous read and write when full is legal.
  - Credit rule guarantees no write when full. A write to a full FIFO is an assertion error; the result is dropped.
- Throughput and latency:
  - Steady state issues 1 operation per cycle with no bubbles when m_res_ready=1 and operands are available.
  - Latency from operand push to m_res_valid ≥ LAT+1.
- Reset mid-batch: rst clears everything, including in-flight overflow bits. The adder shares rst, so in-flight results are lost. No done pulse is produced.
- done and start in the same cycle: start is accepted only in IDLE, the cycle after done.

Test Plan:
- BF16 add: push (0x3F80, 0x3F80, int8=0, sub=0), batch_len=1 → add_b=0x3F80 at issue, m_res=0x4000, m_res_ovf=0, done pulses once.
- BF16 sub: push (0x4040, 0x3F80, sub=1) → add_b=0xBF80, m_res=0x4000.
- INT8 sub: push (0x0005, 0x0003, int8=1, sub=1) → add_b=0x00FD, add_int8=1; m_res matches the adder model for 5+(−3). Also push b=0x0080, sub=1 → add_b=0x0080.
- Back-pressure: RES_DEPTH=4, m_res_ready=0, 8 ops preloaded, batch_len=8 → exactly 4 add_vld pulses, then stall with busy=1. Raise m_res_ready → remaining 4 issue, results come out in order, done after the 8th result is written.
- Overflow: push (0x7F00, 0x7F00) with the adder asserting add_ovf → m_res_ovf=1 on that result only, ovf_count=1. ovf_count clears on the next start.
- Reset mid-batch and corner starts:
  - rst during RUN with 3 ops in flight or buffered → all outputs at reset values next cycle, no done.
  - batch_len=0 → done one cycle after start, no add_vld.
  - start while busy → ignored.

Source files
------------

// File: rtl/addsub_stream_ctrl.sv
// Stream initiator/collector around a single-cycle BF16/INT8 add/sub unit.
// Operand FIFO -> credit-gated issue -> overflow-aligned result FIFO.
module addsub_stream_ctrl #(
    parameter int OP_DEPTH  = 8,
    parameter int RES_DEPTH = 8,
    parameter int LAT       = 1,
    parameter int LW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   s_op_a,
    input  logic [15:0]   s_op_b,
    input  logic          s_op_int8,
    input  logic          s_op_sub,
    input  logic          s_op_valid,
    output logic          s_op_ready,
    input  logic          start,
    input  logic [LW-1:0] batch_len,
    output logic          busy,
    output logic          done,
    output logic [15:0]   add_a,
    output logic [15:0]   add_b,
    output logic          add_int8,
    output logic          add_vld,
    input  logic [15:0]   add_res,
    input  logic          add_res_vld,
    input  logic          add_ovf,
    output logic [15:0]   m_res,
    output logic          m_res_ovf,
    output logic          m_res_valid,
    input  logic          m_res_ready,
    output logic [7:0]    ovf_count
);

    localparam int OPW = $clog2(OP_DEPTH);
    localparam int RSW = $clog2(RES_DEPTH);
    localparam int IFW = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [33:0]   op_mem_q [OP_DEPTH];
    logic [OPW-1:0] op_wr_q, op_rd_q;
    logic [OPW:0]  op_cnt_q;

    logic [16:0]   res_mem_q [RES_DEPTH];
    logic [RSW-1:0] res_wr_q, res_rd_q;
    logic [RSW:0]  res_cnt_q;

    logic [LW-1:0] len_q, issued_q;
    logic [IFW-1:0] inflight_q;
    logic [LAT-1:0] ovf_sr_q;
    logic [7:0]    ovf_cnt_q;
    logic          zdone_q, zdone_d;

    logic          op_push, issue, start_ok, credit_ok;
    logic          res_wr, res_rd, res_full, ovf_dly, drain_done;
    logic [15:0]   h_a, h_b;
    logic          h_int8, h_sub;
    logic [7:0]    b_neg8;

    assign s_op_ready = (op_cnt_q != (OPW+1)'(OP_DEPTH));
    assign op_push    = s_op_valid && s_op_ready;
    assign {h_a, h_b, h_int8, h_sub} = op_mem_q[op_rd_q];
    assign b_neg8     = ~h_b[7:0] + 8'd1;

    assign credit_ok = (32'(res_cnt_q) + 32'(inflight_q)) < 32'(RES_DEPTH);
    assign issue     = (state_q == S_RUN) && (op_cnt_q != '0)
                    && (issued_q < len_q) && credit_ok;
    assign start_ok  = (state_q == S_IDLE) && start && !zdone_q;

    // Subtract is folded into operand b so the adder only ever adds
    always_comb begin
        add_vld  = issue;
        add_a    = 16'h0000;
        add_b    = 16'h0000;
        add_int8 = 1'b0;
        if (issue) begin
            add_a    = h_a;
            add_int8 = h_int8;
            add_b    = h_b;
            if (h_sub) begin
                if (h_int8) add_b = {8'h00, b_neg8};
                else        add_b = {~h_b[15], h_b[14:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (op_push) op_mem_q[op_wr_q] <= {s_op_a, s_op_b, s_op_int8, s_op_sub};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q  <= '0;
            op_rd_q  <= '0;
            op_cnt_q <= '0;
        end else begin
            if (op_push) op_wr_q <= op_wr_q + 1'b1;
            if (issue)   op_rd_q <= op_rd_q + 1'b1;
            if (op_push && !issue)      op_cnt_q <= op_cnt_q + 1'b1;
            else if (!op_push && issue) op_cnt_q <= op_cnt_q - 1'b1;
        end
    end

    assign drain_done = (inflight_q == '0) && !add_res_vld;

    always_comb begin
        state_d = state_q;
        zdone_d = 1'b0;
        done    = zdone_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (batch_len == '0) zdone_d = 1'b1;
                    else                 state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (issued_q + LW'(1) == len_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zdone_q <= zdone_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            ovf_sr_q   <= '0;
        end else begin
            if (start_ok) begin
                len_q    <= batch_len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LW'(1);
            end
            if (issue && !add_res_vld)      inflight_q <= inflight_q + 1'b1;
            else if (!issue && add_res_vld) inflight_q <= inflight_q - 1'b1;
            ovf_sr_q <= (ovf_sr_q << 1) | LAT'(issue && add_ovf);
        end
    end

    assign ovf_dly     = ovf_sr_q[LAT-1];
    assign m_res_valid = (res_cnt_q != '0);
    assign res_full    = (res_cnt_q == (RSW+1)'(RES_DEPTH));
    assign res_rd      = m_res_valid && m_res_ready;
    assign res_wr      = add_res_vld && (!res_full || res_rd);
    assign m_res       = m_res_valid ? res_mem_q[res_rd_q][16:1] : 16'h0000;
    assign m_res_ovf   = m_res_valid && res_mem_q[res_rd_q][0];
    assign ovf_count   = ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (res_wr) res_mem_q[res_wr_q] <= {add_res, ovf_dly};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (res_wr) res_wr_q <= res_wr_q + 1'b1;
            if (res_rd) res_rd_q <= res_rd_q + 1'b1;
            if (res_wr && !res_rd)      res_cnt_q <= res_cnt_q + 1'b1;
            else if (!res_wr && res_rd) res_cnt_q <= res_cnt_q - 1'b1;
            if (start_ok) ovf_cnt_q <= '0;
            else if (res_wr && ovf_dly && ovf_cnt_q != 8'hFF)
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(add_res_vld && res_full && !res_rd));

endmodule
